// File: rtl/ctrl_pkg.sv
// Shared controller-frame definitions: button bit positions and the capture FSM states.
package ctrl_pkg;

  localparam int CTRL_RIGHT  = 0;
  localparam int CTRL_LEFT   = 1;
  localparam int CTRL_JUMP   = 2;
  localparam int CTRL_SQUAT  = 3;
  localparam int CTRL_ATTACK = 4;
  localparam int CTRL_DEFEND = 5;
  localparam int CTRL_SELECT = 6;
  localparam int CTRL_MARKER = 7;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    UPDATE
  } ctrl_state_t;

  // Opposing directions pressed together cancel out rather than letting one side win.
  function automatic logic [6:0] resolve_dpad(input logic [6:0] btn);
    logic [6:0] res;
    res = btn;
    if (btn[CTRL_RIGHT] && btn[CTRL_LEFT]) begin
      res[CTRL_RIGHT] = 1'b0;
      res[CTRL_LEFT]  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/ctrl_frame_hold_sync_rise.sv
// Two-flop synchroniser for an asynchronous level plus a history flop that
// turns its synchronised rising edge into a single-cycle pulse.
module sync_rise (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic s1;
  logic s2;
  logic s3;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign o_rise = s2 & ~s3;

endmodule

// File: rtl/ctrl_frame_hold.sv
// Captures controller bytes from the slow UART domain, validates the frame
// marker and presents held buttons, press pulses and link-loss to the core.
module ctrl_frame_hold
  import ctrl_pkg::*;
#(
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 10_800_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic [6:0] o_held,
  output logic [6:0] o_press,
  output logic       o_link_lost,
  output logic [7:0] o_frame_cnt,
  output logic [7:0] o_drop_cnt
);

  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  ctrl_state_t   state;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    cap;
  logic [6:0]    frame_btn;
  logic          valid_rise;

  sync_rise u_sync_rise (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_valid),
    .o_rise  (valid_rise)
  );

  assign frame_btn = resolve_dpad(cap[6:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      cap         <= '0;
      o_held      <= '0;
      o_press     <= '0;
      o_link_lost <= 1'b1;
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      o_press <= '0;

      if (!o_link_lost) begin
        if (to_cnt == TIMEOUT_LAST) begin
          o_held      <= '0;
          o_link_lost <= 1'b1;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      // An accepted frame is assigned after the timeout so it overrides a coincident release.
      case (state)
        IDLE: begin
          if (valid_rise) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        CAPTURE: begin
          cap   <= i_byte;
          state <= UPDATE;
        end
        UPDATE: begin
          state <= IDLE;
          if (cap[CTRL_MARKER]) begin
            o_held      <= frame_btn;
            o_press     <= frame_btn & ~o_held;
            o_frame_cnt <= o_frame_cnt + 8'd1;
            to_cnt      <= '0;
            o_link_lost <= 1'b0;
          end else if (o_drop_cnt != 8'hFF) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
